mem_access_unit: RTL and testbench

- Memory stage of the 5-stage pipeline. Sits directly downstream of the EX/MEM pipeline register and upstream of MEM/WB.
- Decodes the load/store instr_id latched in EX/MEM and runs a valid/ready transaction on the data-memory port.
- Handles byte-lane alignment, store strobes, load sign/zero extension, misalignment detection and response timeout.
- Raises mem_stall, which is ORed into the global pipeline freeze (the cache_stall input of the pipeline registers).

---
 rtl/mem_access_unit_pkg.sv | 59 +++++
 rtl/mem_access_unit_if.sv | 23 ++
 rtl/mem_access_unit_align.sv | 55 +++++
 rtl/mem_access_unit.sv | 138 +++++++++++++
 tb/tb_mem_access_unit.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the memory stage: instruction IDs, FSM states, decoded op.
package mem_access_unit_pkg;

    localparam int unsigned INSTR_W = 6;
    localparam int unsigned XLEN    = 32;
    localparam int unsigned STRB_W  = 4;
    localparam int unsigned REG_W   = 5;

    typedef logic [INSTR_W-1:0] instr_id_t;

    localparam instr_id_t INSTR_LB  = 6'd1;
    localparam instr_id_t INSTR_LH  = 6'd2;
    localparam instr_id_t INSTR_LW  = 6'd3;
    localparam instr_id_t INSTR_LBU = 6'd4;
    localparam instr_id_t INSTR_LHU = 6'd5;
    localparam instr_id_t INSTR_SB  = 6'd6;
    localparam instr_id_t INSTR_SH  = 6'd7;
    localparam instr_id_t INSTR_SW  = 6'd8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } mau_state_e;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } acc_size_e;

    typedef struct packed {
        logic      is_mem;
        logic      is_store;
        logic      is_signed;
        acc_size_e size;
    } mem_op_t;

    // Classify an instruction ID; non-memory IDs decode to is_mem=0.
    function automatic mem_op_t decode_op(input instr_id_t id);
        mem_op_t op;
        op      = '0;
        op.size = SZ_WORD;
        case (id)
            INSTR_LB:  begin op.is_mem = 1'b1; op.is_signed = 1'b1; op.size = SZ_BYTE; end
            INSTR_LH:  begin op.is_mem = 1'b1; op.is_signed = 1'b1; op.size = SZ_HALF; end
            INSTR_LW:  begin op.is_mem = 1'b1; op.size = SZ_WORD; end
            INSTR_LBU: begin op.is_mem = 1'b1; op.size = SZ_BYTE; end
            INSTR_LHU: begin op.is_mem = 1'b1; op.size = SZ_HALF; end
            INSTR_SB:  begin op.is_mem = 1'b1; op.is_store = 1'b1; op.size = SZ_BYTE; end
            INSTR_SH:  begin op.is_mem = 1'b1; op.is_store = 1'b1; op.size = SZ_HALF; end
            INSTR_SW:  begin op.is_mem = 1'b1; op.is_store = 1'b1; op.size = SZ_WORD; end
            default:   op = op;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-memory valid/ready port between the memory stage (master) and data memory (slave).
interface mem_access_unit_if;
    import mem_access_unit_pkg::*;

    logic              dmem_req_valid;
    logic              dmem_req_ready;
    logic              dmem_we;
    logic [XLEN-1:0]   dmem_addr;
    logic [XLEN-1:0]   dmem_wdata;
    logic [STRB_W-1:0] dmem_wstrb;
    logic              dmem_rsp_valid;
    logic [XLEN-1:0]   dmem_rdata;

    modport master (
        output dmem_req_valid, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
        input  dmem_req_ready, dmem_rsp_valid, dmem_rdata
    );

    modport slave (
        input  dmem_req_valid, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
        output dmem_req_ready, dmem_rsp_valid, dmem_rdata
    );
endinterface

// File: rtl/mem_access_unit_align.sv
// Byte-lane steering: store strobes/data, load lane extraction and extension, misalignment.
module load_store_align
    import mem_access_unit_pkg::*;
(
    input  logic [INSTR_W-1:0] instr_id_i,
    input  logic [1:0]         addr_lo_i,
    input  logic [XLEN-1:0]    rs2_i,
    input  logic [XLEN-1:0]    rdata_i,
    output logic               is_mem_o,
    output logic               is_store_o,
    output logic               misaligned_o,
    output logic [STRB_W-1:0]  wstrb_o,
    output logic [XLEN-1:0]    wdata_o,
    output logic [XLEN-1:0]    load_data_o
);
    mem_op_t    op;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    // Decode, select lanes and extend according to access size.
    always_comb begin
        op           = decode_op(instr_id_i);
        lane_b       = rdata_i[{addr_lo_i, 3'b000} +: 8];
        lane_h       = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        is_mem_o     = op.is_mem;
        is_store_o   = op.is_store;
        misaligned_o = 1'b0;
        wstrb_o      = '0;
        wdata_o      = rs2_i;
        load_data_o  = rdata_i;
        case (op.size)
            SZ_BYTE: begin
                wstrb_o     = 4'b0001 << addr_lo_i;
                wdata_o     = {4{rs2_i[7:0]}};
                load_data_o = op.is_signed ? {{24{lane_b[7]}}, lane_b} : {24'b0, lane_b};
            end
            SZ_HALF: begin
                misaligned_o = addr_lo_i[0];
                wstrb_o      = 4'b0011 << addr_lo_i;
                wdata_o      = {2{rs2_i[15:0]}};
                load_data_o  = op.is_signed ? {{16{lane_h[15]}}, lane_h} : {16'b0, lane_h};
            end
            default: begin
                misaligned_o = (addr_lo_i != 2'b00);
                wstrb_o      = 4'b1111;
            end
        endcase
        if (!op.is_store) begin
            wstrb_o = '0;
        end
        if (!op.is_mem) begin
            misaligned_o = 1'b0;
        end
    end
endmodule

// File: rtl/mem_access_unit.sv
// Pipeline memory stage: issues load/store transactions on the dmem port and stalls until done.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_WIDTH      = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pipe_stall_in,
    input  logic [INSTR_W-1:0] instr_id_in,
    input  logic [XLEN-1:0]    mem_addr_in,
    input  logic [XLEN-1:0]    rs2_value_in,
    input  logic [XLEN-1:0]    exec_output_in,
    input  logic [REG_W-1:0]   rd_addr_in,
    input  logic               rd_valid_in,
    mem_access_unit_if.master  dmem,
    output logic               mem_stall,
    output logic [XLEN-1:0]    mem_result,
    output logic [REG_W-1:0]   rd_addr_out,
    output logic               rd_valid_out,
    output logic               misaligned_fault,
    output logic               bus_error
);
    mau_state_e           state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0]      rdata_q, rdata_d;
    logic                 err_q, err_d;

    logic                 is_mem;
    logic                 is_store;
    logic                 misaligned;
    logic [STRB_W-1:0]    wstrb;
    logic [XLEN-1:0]      wdata;
    logic [XLEN-1:0]      load_data;
    logic                 drive_req;

    load_store_align u_align (
        .instr_id_i   (instr_id_in),
        .addr_lo_i    (mem_addr_in[1:0]),
        .rs2_i        (rs2_value_in),
        .rdata_i      (rdata_q),
        .is_mem_o     (is_mem),
        .is_store_o   (is_store),
        .misaligned_o (misaligned),
        .wstrb_o      (wstrb),
        .wdata_o      (wdata),
        .load_data_o  (load_data)
    );

    assign rd_addr_out = rd_addr_in;

    // State, timeout counter, read-data latch and error latch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic and combinational outputs.
    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        rdata_d          = rdata_q;
        err_d            = err_q;
        drive_req        = 1'b0;
        mem_stall        = 1'b0;
        mem_result       = '0;
        rd_valid_out     = 1'b0;
        misaligned_fault = 1'b0;
        bus_error        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!is_mem) begin
                    mem_result   = exec_output_in;
                    rd_valid_out = rd_valid_in;
                end else if (misaligned) begin
                    misaligned_fault = 1'b1;
                end else begin
                    drive_req = 1'b1;
                    mem_stall = 1'b1;
                    cnt_d     = '0;
                    err_d     = 1'b0;
                    state_d   = dmem.dmem_req_ready ? ST_WAIT : ST_REQ;
                end
            end
            ST_REQ: begin
                drive_req = 1'b1;
                mem_stall = 1'b1;
                if (dmem.dmem_req_ready) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                mem_stall = 1'b1;
                cnt_d     = cnt_q + CNT_WIDTH'(1);
                if (dmem.dmem_rsp_valid) begin
                    rdata_d = dmem.dmem_rdata;
                    state_d = ST_DONE;
                end else if ((TIMEOUT_CYCLES != 0) && (cnt_d == CNT_WIDTH'(TIMEOUT_CYCLES))) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (err_q) begin
                    bus_error = 1'b1;
                end else if (!is_store) begin
                    mem_result   = load_data;
                    rd_valid_out = rd_valid_in;
                end
                if (!pipe_stall_in) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        dmem.dmem_req_valid = drive_req;
        dmem.dmem_we        = drive_req & is_store;
        dmem.dmem_addr      = drive_req ? {mem_addr_in[XLEN-1:2], 2'b00} : '0;
        dmem.dmem_wdata     = drive_req ? wdata : '0;
        dmem.dmem_wstrb     = drive_req ? wstrb : '0;
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed + randomized checks of mem_access_unit against a lane/extension reference model.
module tb_mem_access_unit;
    import mem_access_unit_pkg::*;

    localparam int unsigned TMO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        pipe_stall_in;
    logic [5:0]  instr_id_in;
    logic [31:0] mem_addr_in;
    logic [31:0] rs2_value_in;
    logic [31:0] exec_output_in;
    logic [4:0]  rd_addr_in;
    logic        rd_valid_in;
    logic        mem_stall;
    logic [31:0] mem_result;
    logic [4:0]  rd_addr_out;
    logic        rd_valid_out;
    logic        misaligned_fault;
    logic        bus_error;

    int n_assert = 0;
    int n_fail   = 0;

    mem_access_unit_if dmem_if ();

    mem_access_unit #(.TIMEOUT_CYCLES(TMO), .CNT_WIDTH(8)) dut (
        .clk              (clk),
        .rst              (rst),
        .pipe_stall_in    (pipe_stall_in),
        .instr_id_in      (instr_id_in),
        .mem_addr_in      (mem_addr_in),
        .rs2_value_in     (rs2_value_in),
        .exec_output_in   (exec_output_in),
        .rd_addr_in       (rd_addr_in),
        .rd_valid_in      (rd_valid_in),
        .dmem             (dmem_if.master),
        .mem_stall        (mem_stall),
        .mem_result       (mem_result),
        .rd_addr_out      (rd_addr_out),
        .rd_valid_out     (rd_valid_out),
        .misaligned_fault (misaligned_fault),
        .bus_error        (bus_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference model: access width in bytes, lanes and extension by plain arithmetic.
    function automatic bit m_is_load(input logic [5:0] id);
        return id inside {INSTR_LB, INSTR_LH, INSTR_LW, INSTR_LBU, INSTR_LHU};
    endfunction

    function automatic bit m_is_store(input logic [5:0] id);
        return id inside {INSTR_SB, INSTR_SH, INSTR_SW};
    endfunction

    function automatic int unsigned m_bytes(input logic [5:0] id);
        if (id inside {INSTR_LB, INSTR_LBU, INSTR_SB}) return 1;
        if (id inside {INSTR_LH, INSTR_LHU, INSTR_SH}) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] m_load(input logic [5:0] id, input logic [31:0] addr,
                                           input logic [31:0] rdata);
        int unsigned nb;
        logic [31:0] v;
        nb = m_bytes(id);
        v  = rdata >> (8 * (addr % 4));
        if (nb == 1) begin
            v = v & 32'hFF;
            if (id == INSTR_LB && v >= 32'd128) v = v + 32'hFFFF_FF00;
        end else if (nb == 2) begin
            v = v & 32'hFFFF;
            if (id == INSTR_LH && v >= 32'd32768) v = v + 32'hFFFF_0000;
        end
        return v;
    endfunction

    function automatic logic [31:0] m_strb(input logic [5:0] id, input logic [31:0] addr);
        int unsigned nb;
        nb = m_bytes(id);
        return ((32'd1 << nb) - 32'd1) << (addr % 4);
    endfunction

    function automatic logic [31:0] m_wdata(input logic [5:0] id, input logic [31:0] rs2);
        int unsigned nb;
        nb = m_bytes(id);
        if (nb == 1) return (rs2 & 32'hFF) * 32'h0101_0101;
        if (nb == 2) return (rs2 & 32'hFFFF) * 32'h0001_0001;
        return rs2;
    endfunction

    task automatic chk_req(input logic [5:0] id, input logic [31:0] addr, input logic [31:0] rs2);
        chk("req_valid", 32'(dmem_if.dmem_req_valid), 32'd1);
        chk("req_stall", 32'(mem_stall), 32'd1);
        chk("req_we", 32'(dmem_if.dmem_we), 32'(m_is_store(id)));
        chk("req_addr", dmem_if.dmem_addr, addr & 32'hFFFF_FFFC);
        if (m_is_store(id)) begin
            chk("req_wstrb", 32'(dmem_if.dmem_wstrb), m_strb(id, addr));
            chk("req_wdata", dmem_if.dmem_wdata, m_wdata(id, rs2));
        end else begin
            chk("req_wstrb_ld", 32'(dmem_if.dmem_wstrb), 32'd0);
        end
    endtask

    // One instruction through the stage; rsp_lat outside 1..TMO means no response.
    task automatic run_op(input logic [5:0] id, input logic [31:0] addr, input logic [31:0] rs2,
                          input logic [31:0] exec, input logic [4:0] rd, input logic rdv,
                          input int ready_lat, input int rsp_lat, input logic [31:0] rdata,
                          input int done_hold);
        bit mem, mis, timed_out;
        int nwait;
        logic [31:0] exp_res;
        logic        exp_rdv;
        mem = m_is_load(id) || m_is_store(id);
        mis = mem && ((addr % m_bytes(id)) != 0);
        instr_id_in    = id;
        mem_addr_in    = addr;
        rs2_value_in   = rs2;
        exec_output_in = exec;
        rd_addr_in     = rd;
        rd_valid_in    = rdv;
        pipe_stall_in  = 1'b0;
        dmem_if.dmem_req_ready = (ready_lat == 0);
        dmem_if.dmem_rsp_valid = 1'b0;
        dmem_if.dmem_rdata     = $urandom;
        #1;
        chk("rd_addr_out", 32'(rd_addr_out), 32'(rd));
        if (!mem) begin
            chk("pass_result", mem_result, exec);
            chk("pass_rdv", 32'(rd_valid_out), 32'(rdv));
            chk("pass_stall", 32'(mem_stall), 32'd0);
            chk("pass_req", 32'(dmem_if.dmem_req_valid), 32'd0);
            chk("pass_fault", 32'(misaligned_fault), 32'd0);
        end else if (mis) begin
            chk("mis_fault", 32'(misaligned_fault), 32'd1);
            chk("mis_req", 32'(dmem_if.dmem_req_valid), 32'd0);
            chk("mis_stall", 32'(mem_stall), 32'd0);
            chk("mis_rdv", 32'(rd_valid_out), 32'd0);
            chk("mis_result", mem_result, 32'd0);
        end else begin
            chk("mis_none", 32'(misaligned_fault), 32'd0);
            chk_req(id, addr, rs2);
            for (int k = 1; k <= ready_lat; k++) begin
                @(posedge clk); #1;
                dmem_if.dmem_req_ready = (k == ready_lat);
                #1;
                chk_req(id, addr, rs2);
            end
            timed_out = (rsp_lat < 1) || (rsp_lat > int'(TMO));
            nwait = timed_out ? int'(TMO) : rsp_lat;
            for (int w = 1; w <= nwait; w++) begin
                @(posedge clk); #1;
                dmem_if.dmem_req_ready = 1'b0;
                dmem_if.dmem_rsp_valid = !timed_out && (w == nwait);
                dmem_if.dmem_rdata     = (w == nwait) ? rdata : $urandom;
                #1;
                chk("wait_stall", 32'(mem_stall), 32'd1);
                chk("wait_req", 32'(dmem_if.dmem_req_valid), 32'd0);
                chk("wait_buserr", 32'(bus_error), 32'd0);
            end
            @(posedge clk); #1;
            dmem_if.dmem_rsp_valid = 1'b0;
            dmem_if.dmem_rdata     = $urandom;
            if (timed_out || m_is_store(id)) begin
                exp_res = 32'd0;
                exp_rdv = 1'b0;
            end else begin
                exp_res = m_load(id, addr, rdata);
                exp_rdv = rdv;
            end
            for (int h = 0; h <= done_hold; h++) begin
                pipe_stall_in = (h < done_hold);
                #1;
                chk("done_stall", 32'(mem_stall), 32'd0);
                chk("done_result", mem_result, exp_res);
                chk("done_rdv", 32'(rd_valid_out), 32'(exp_rdv));
                chk("done_buserr", 32'(bus_error), 32'(timed_out));
                chk("done_req", 32'(dmem_if.dmem_req_valid), 32'd0);
                if (h < done_hold) begin
                    @(posedge clk); #1;
                end
            end
        end
        pipe_stall_in = 1'b0;
        @(posedge clk); #1;
    endtask

    logic [5:0]  ops [8];
    logic [5:0]  r_id;
    logic [31:0] r_addr;
    int          sel;

    initial begin
        ops = '{INSTR_LB, INSTR_LH, INSTR_LW, INSTR_LBU, INSTR_LHU, INSTR_SB, INSTR_SH, INSTR_SW};
        rst = 1'b1;
        pipe_stall_in  = 1'b0;
        instr_id_in    = '0;
        mem_addr_in    = '0;
        rs2_value_in   = '0;
        exec_output_in = '0;
        rd_addr_in     = '0;
        rd_valid_in    = 1'b0;
        dmem_if.dmem_req_ready = 1'b0;
        dmem_if.dmem_rsp_valid = 1'b0;
        dmem_if.dmem_rdata     = '0;
        #1;
        chk("rst_stall", 32'(mem_stall), 32'd0);
        chk("rst_result", mem_result, 32'd0);
        chk("rst_rdv", 32'(rd_valid_out), 32'd0);
        chk("rst_req", 32'(dmem_if.dmem_req_valid), 32'd0);
        chk("rst_fault", 32'(misaligned_fault), 32'd0);
        chk("rst_buserr", 32'(bus_error), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        // Directed scenarios
        run_op(INSTR_LW,  32'h100, 32'h0, 32'h55, 5'd3, 1'b1, 0, 1, 32'hDEAD_BEEF, 0);
        run_op(INSTR_LB,  32'h103, 32'h0, 32'h0, 5'd4, 1'b1, 0, 1, 32'h80FF_1234, 0);
        run_op(INSTR_LBU, 32'h103, 32'h0, 32'h0, 5'd4, 1'b1, 0, 1, 32'h80FF_1234, 0);
        run_op(INSTR_LH,  32'h102, 32'h0, 32'h0, 5'd5, 1'b1, 0, 2, 32'h80FF_1234, 0);
        run_op(INSTR_SH,  32'h102, 32'h0000_ABCD, 32'h0, 5'd6, 1'b1, 0, 1, 32'h0, 0);
        run_op(INSTR_LW,  32'h101, 32'h0, 32'h0, 5'd7, 1'b1, 0, 1, 32'h0, 0);
        run_op(INSTR_SW,  32'h200, 32'h1234_5678, 32'h0, 5'd1, 1'b0, 3, 2, 32'h0, 0);
        run_op(INSTR_LW,  32'h204, 32'h0, 32'h0, 5'd2, 1'b1, 1, 0, 32'h0, 0);
        run_op(INSTR_LHU, 32'h206, 32'h0, 32'h0, 5'd2, 1'b1, 0, int'(TMO), 32'h8001_7FFF, 0);
        run_op(INSTR_LB,  32'h301, 32'h0, 32'h0, 5'd9, 1'b1, 0, 1, 32'h0000_7F00, 3);
        run_op(6'd0,      32'h0,   32'h0, 32'hCAFE_F00D, 5'd10, 1'b1, 0, 0, 32'h0, 0);

        // Reset pulsed while waiting for a response
        instr_id_in = INSTR_LW;
        mem_addr_in = 32'h400;
        rd_valid_in = 1'b1;
        dmem_if.dmem_req_ready = 1'b1;
        @(posedge clk); #1;
        dmem_if.dmem_req_ready = 1'b0;
        #1;
        chk("rstw_pre_stall", 32'(mem_stall), 32'd1);
        rst = 1'b1;
        instr_id_in = '0;
        #1;
        chk("rstw_req", 32'(dmem_if.dmem_req_valid), 32'd0);
        chk("rstw_stall", 32'(mem_stall), 32'd0);
        chk("rstw_buserr", 32'(bus_error), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        run_op(INSTR_LW, 32'h408, 32'h0, 32'h0, 5'd11, 1'b1, 0, 3, 32'h0BAD_F00D, 0);

        // Randomized traffic
        for (int i = 0; i < 60; i++) begin
            sel = int'($urandom_range(0, 9));
            if (sel == 0)      r_id = 6'd0;
            else if (sel == 9) r_id = 6'($urandom_range(9, 63));
            else               r_id = ops[sel-1];
            r_addr = $urandom;
            if ($urandom_range(0, 2) != 0) r_addr = r_addr & ~(32'(m_bytes(r_id)) - 32'd1);
            run_op(r_id, r_addr, $urandom, $urandom, 5'($urandom_range(0, 31)),
                   1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                   int'($urandom_range(0, 5)), $urandom, int'($urandom_range(0, 2)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
